// File: rtl/conv_result_drain_pkg.sv
// conv_result_drain_pkg: shared state encoding and default geometry for the
// convolution result drain. Optional feature macro: CONV_RESULT_DRAIN_DBUF_EN.
package conv_result_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Width of the beat index; a single-beat frame still needs one bit.
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DATA_WIDTH_DEF = 8;
    localparam int RESULT_D_DEF   = 4;
    localparam int RESULT_H_DEF   = 6;
    localparam int RESULT_W_DEF   = 6;
    localparam int OUT_LANES_DEF  = 4;
    localparam int TAG_WIDTH      = 8;

    localparam int N         = RESULT_D_DEF * RESULT_H_DEF * RESULT_W_DEF;
    localparam int NUM_BEATS = N / OUT_LANES_DEF;
    localparam int BEAT_W    = beat_width(NUM_BEATS);

endpackage

// File: rtl/conv_result_drain_slot.sv
// conv_result_drain_slot: one frame-plus-tag holding register with a full flag.
// Load wins over clear when both are asserted in the same cycle.
// Optional feature macro (used by the parent): CONV_RESULT_DRAIN_DBUF_EN.
module conv_result_drain_slot
    import conv_result_drain_pkg::*;
#(
    parameter int FRAME_BITS = N * DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic [FRAME_BITS-1:0] frame,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  full
);

    // Capture frame and tag on load; track occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame <= '0;
            tag   <= '0;
            full  <= 1'b0;
        end else begin
            if (load) begin
                frame <= frame_in;
                tag   <= tag_in;
            end
            if (load) begin
                full <= 1'b1;
            end else if (clear) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// conv_result_drain: accepts a whole flattened result frame in one handshake
// and streams it out OUT_LANES elements per beat, lowest element index first.
// Optional feature macro: CONV_RESULT_DRAIN_DBUF_EN (pending slot, zero-bubble
// frame-to-frame streaming).
//
// state  | meaning
// IDLE   | no active frame, ready to capture one
// STREAM | active frame being presented beat by beat
module conv_result_drain
    import conv_result_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RESULT_D   = RESULT_D_DEF,
    parameter int RESULT_H   = RESULT_H_DEF,
    parameter int RESULT_W   = RESULT_W_DEF,
    parameter int OUT_LANES  = OUT_LANES_DEF,
    localparam int FRAME_N     = RESULT_D * RESULT_H * RESULT_W,
    localparam int FRAME_BEATS = FRAME_N / OUT_LANES,
    localparam int IDX_W       = beat_width(FRAME_BEATS),
    localparam int FRAME_BITS  = FRAME_N * DATA_WIDTH,
    localparam int BEAT_BITS   = OUT_LANES * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAME_BITS-1:0] result_data_in,
    input  logic [TAG_WIDTH-1:0]  opaque_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_BITS-1:0]  out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic [TAG_WIDTH-1:0]  out_opaque
);

    if ((FRAME_N % OUT_LANES) != 0) begin : g_bad_lanes
        $error("conv_result_drain: OUT_LANES must divide the frame element count");
    end

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(FRAME_BEATS - 1);

    state_t state, state_nxt;
    logic [IDX_W-1:0]      beat;
    logic                  accept, stream_valid, beat_hs, last_hs, reload;
    logic                  act_load, act_clear, act_full;
    logic [FRAME_BITS-1:0] act_frame, act_frame_in;
    logic [TAG_WIDTH-1:0]  act_tag, act_tag_in;

    assign stream_valid = (state == STREAM) && act_full;
    assign beat_hs      = stream_valid && out_ready;
    assign last_hs      = beat_hs && (beat == LAST_BEAT);
    assign accept       = in_valid && in_ready;

`ifdef CONV_RESULT_DRAIN_DBUF_EN
    logic                  pend_load, pend_clear, pend_full;
    logic [FRAME_BITS-1:0] pend_frame;
    logic [TAG_WIDTH-1:0]  pend_tag;

    // Ready only depends on the pending slot, so a frame can queue while the
    // active one is still streaming; reset forces it low while held.
    assign in_ready   = reset && !pend_full;
    assign pend_load  = accept && (state == STREAM) && !last_hs;
    assign pend_clear = last_hs && pend_full;
    // A frame accepted on the very last handshake bypasses the pending slot.
    assign reload       = last_hs && (pend_full || accept);
    assign act_load     = (accept && (state == IDLE)) || reload;
    assign act_clear    = last_hs && !reload;
    assign act_frame_in = pend_full ? pend_frame : result_data_in;
    assign act_tag_in   = pend_full ? pend_tag : opaque_in;

    conv_result_drain_slot #(.FRAME_BITS(FRAME_BITS)) u_pend (
        .clk      (clk),
        .reset    (reset),
        .load     (pend_load),
        .clear    (pend_clear),
        .frame_in (result_data_in),
        .tag_in   (opaque_in),
        .frame    (pend_frame),
        .tag      (pend_tag),
        .full     (pend_full)
    );
`else
    assign in_ready     = reset && (state == IDLE);
    assign reload       = 1'b0;
    assign act_load     = accept;
    assign act_clear    = last_hs;
    assign act_frame_in = result_data_in;
    assign act_tag_in   = opaque_in;
`endif

    conv_result_drain_slot #(.FRAME_BITS(FRAME_BITS)) u_active (
        .clk      (clk),
        .reset    (reset),
        .load     (act_load),
        .clear    (act_clear),
        .frame_in (act_frame_in),
        .tag_in   (act_tag_in),
        .frame    (act_frame),
        .tag      (act_tag),
        .full     (act_full)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and beat-level handshake outputs.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                out_valid = stream_valid;
                out_last  = stream_valid && (beat == LAST_BEAT);
                if (last_hs && !reload) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counter: parked at zero outside a stream, restarts for every frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat <= '0;
        end else if ((state == IDLE) || last_hs) begin
            beat <= '0;
        end else if (beat_hs) begin
            beat <= beat + IDX_W'(1);
        end
    end

    assign out_data   = act_frame[int'(beat) * BEAT_BITS +: BEAT_BITS];
    assign out_idx    = beat;
    assign out_opaque = act_tag;

endmodule

// File: tb/tb_conv_result_drain.sv
// tb_conv_result_drain: directed checks of the result drain with a default
// 36-beat instance and a single-beat (OUT_LANES = 144) instance sharing inputs.
// Expectations adapt when CONV_RESULT_DRAIN_DBUF_EN is defined.
module tb_conv_result_drain;

    localparam int NB = 36;
    localparam int FB = 1152;

    logic          clk = 1'b0;
    logic          reset, in_valid, out_ready;
    logic [FB-1:0] result_data_in;
    logic [7:0]    opaque_in;

    logic          in_ready, out_valid, out_last;
    logic [31:0]   out_data;
    logic [5:0]    out_idx;
    logic [7:0]    out_opaque;

    logic          one_in_ready, one_out_valid, one_out_last;
    logic [FB-1:0] one_out_data;
    logic [0:0]    one_out_idx;
    logic [7:0]    one_out_opaque;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_result_drain u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .result_data_in (result_data_in),
        .opaque_in      (opaque_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .out_opaque     (out_opaque)
    );

    conv_result_drain #(.OUT_LANES(144)) u_one (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (one_in_ready),
        .result_data_in (result_data_in),
        .opaque_in      (opaque_in),
        .out_valid      (one_out_valid),
        .out_ready      (out_ready),
        .out_data       (one_out_data),
        .out_idx        (one_out_idx),
        .out_last       (one_out_last),
        .out_opaque     (one_out_opaque)
    );

    task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element k of a frame is (base + k) mod 256.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] base);
        logic [FB-1:0] f;
        f = '0;
        for (int k = 0; k < 144; k++) f[k*8 +: 8] = base + 8'(k);
        return f;
    endfunction

    function automatic logic [31:0] beat_of(input logic [7:0] base, input int b);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = base + 8'(4*b + j);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk beats 0..stop-1, checking every presented beat (stalled beats are
    // re-checked against the same expectation, so they must hold still).
    task automatic stream(input logic [7:0] base, input logic [7:0] tag, input bit rnd,
                          input bit drop_iv, input int stop);
        int b   = 0;
        int cyc = 0;
        bit take;
        while (b < stop && cyc < 400) begin
            check("out_valid", out_valid, 1'b1);
            check("out_idx", out_idx, b);
            check("out_data", out_data, beat_of(base, b));
            check("out_opaque", out_opaque, tag);
            check("out_last", out_last, (b == NB - 1));
            take = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = take;
            tick();
            cyc++;
            if (drop_iv && cyc == 1) in_valid = 1'b0;
            if (take) b++;
        end
        check("stream_beats_done", b, stop);
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        result_data_in = '0;
        opaque_in      = 8'h00;
        tick();
        tick();

        // reset state
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_opaque", out_opaque, 0);
        check("rst_one_out_last", one_out_last, 1'b0);
        check("rst_one_in_ready", one_in_ready, 1'b0);

        reset = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        // frame k=k, tag A5, always ready
        in_valid       = 1'b1;
        result_data_in = frame_of(8'h00);
        opaque_in      = 8'hA5;
        out_ready      = 1'b1;
        tick();
        in_valid = 1'b0;
        check("first_beat_latency", out_valid, 1'b1);
        check("beat0_data", out_data, 32'h03020100);
`ifdef CONV_RESULT_DRAIN_DBUF_EN
        check("stream_in_ready", in_ready, 1'b1);
`else
        check("stream_in_ready", in_ready, 1'b0);
`endif
        check("one_valid", one_out_valid, 1'b1);
        check("one_last", one_out_last, 1'b1);
        check("one_idx", one_out_idx, 0);
        check("one_data", one_out_data, frame_of(8'h00));
        check("one_opaque", one_out_opaque, 8'hA5);
        stream(8'h00, 8'hA5, 1'b0, 1'b0, NB);
        check("end_out_valid", out_valid, 1'b0);
        check("end_in_ready", in_ready, 1'b1);

        // random backpressure
        in_valid       = 1'b1;
        result_data_in = frame_of(8'h30);
        opaque_in      = 8'h3C;
        tick();
        in_valid = 1'b0;
        stream(8'h30, 8'h3C, 1'b1, 1'b0, NB);
        check("rnd_end_out_valid", out_valid, 1'b0);

        // back-to-back frames; second frame offered while the first streams
        in_valid       = 1'b1;
        result_data_in = frame_of(8'h00);
        opaque_in      = 8'h11;
        tick();
        result_data_in = frame_of(8'h40);
        opaque_in      = 8'h22;
`ifdef CONV_RESULT_DRAIN_DBUF_EN
        check("b2b_in_ready", in_ready, 1'b1);
        stream(8'h00, 8'h11, 1'b0, 1'b1, NB);
`else
        check("b2b_in_ready", in_ready, 1'b0);
        stream(8'h00, 8'h11, 1'b0, 1'b0, NB);
        check("gap_out_valid", out_valid, 1'b0);
        check("gap_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
`endif
        stream(8'h40, 8'h22, 1'b0, 1'b0, NB);
        check("b2b_end_out_valid", out_valid, 1'b0);

        // reset mid-stream at beat 10
        in_valid       = 1'b1;
        result_data_in = frame_of(8'h20);
        opaque_in      = 8'h77;
        tick();
        in_valid = 1'b0;
        stream(8'h20, 8'h77, 1'b0, 1'b0, 10);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_opaque", out_opaque, 0);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        in_valid       = 1'b1;
        result_data_in = frame_of(8'h80);
        opaque_in      = 8'h5A;
        tick();
        in_valid = 1'b0;
        stream(8'h80, 8'h5A, 1'b0, 1'b0, NB);
        check("final_out_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
